// File: rtl/fosfor_present_pkg.sv
// Shared definitions for the PRESENT front end: data widths, frame lengths
// and the loader state encoding.
package fosfor_present_pkg;

  localparam int PRESENT_KEY_W   = 80;
  localparam int PRESENT_BLOCK_W = 64;
  localparam int NIBBLE_W        = 4;
  localparam int KEY_NIBBLES     = PRESENT_KEY_W / NIBBLE_W;    // 20
  localparam int DATA_NIBBLES    = PRESENT_BLOCK_W / NIBBLE_W;  // 16
  localparam int FRAME_NIBBLES   = KEY_NIBBLES + DATA_NIBBLES;  // 36
  localparam int COUNT_W         = 6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_KEY  = 2'd1,
    LOAD_DATA = 2'd2,
    OFFER     = 2'd3
  } loader_state_e;

endpackage

// File: rtl/fosfor_edge_detect.sv
// Registered rising-edge detector.
// Ports:
//   i_clk    clock
//   i_reset  synchronous active-high reset; loads the history flop with RESET_VAL
//   i_sig    level input
//   o_rise   high for the one cycle where i_sig is high and was low last cycle
// With RESET_VAL = 1 a level that is already high when reset releases is
// not reported as an edge.
module fosfor_edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sig,
  output logic o_rise
);

  logic r_q;

  // NOTE: clocked state is always assigned with <= so every flop samples
  // pre-edge values and simulation matches the synthesized registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_q <= RESET_VAL;
    else         r_q <= i_sig;
  end

  assign o_rise = i_sig & ~r_q;

endmodule

// File: rtl/fosfor_present_loader.sv
// Assembles an 80-bit key and a 64-bit plaintext block from strobed nibbles
// and offers them to the PRESENT core over a valid/ready handshake.
// Ports:
//   i_clk          clock
//   i_reset        synchronous active-high reset
//   i_nibble       input nibble, shifted in MSB-first on each strobe rising edge
//   i_strobe       transfer strobe (level; only rising edges count)
//   i_mode         frame type on a frame's first strobe: 1 = key+data, 0 = data only
//   i_ready        core accepts when high during o_valid
//   o_key          assembled key, stable while o_valid
//   o_data         assembled plaintext, stable while o_valid
//   o_valid        key+block offered to the core
//   o_busy         frame in progress
//   o_key_loaded   a complete key has been loaded since reset
//   o_overrun      sticky: a strobe edge arrived while the block was on offer
//   o_count        nibbles received in the current frame (debug)
module fosfor_present_loader
  import fosfor_present_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [NIBBLE_W-1:0]        i_nibble,
  input  logic                       i_strobe,
  input  logic                       i_mode,
  input  logic                       i_ready,
  output logic [PRESENT_KEY_W-1:0]   o_key,
  output logic [PRESENT_BLOCK_W-1:0] o_data,
  output logic                       o_valid,
  output logic                       o_busy,
  output logic                       o_key_loaded,
  output logic                       o_overrun,
  output logic [COUNT_W-1:0]         o_count
);

  loader_state_e                r_state, w_state_next;
  logic [PRESENT_KEY_W-1:0]     r_key;
  logic [PRESENT_BLOCK_W-1:0]   r_data;
  logic [COUNT_W-1:0]           r_count;
  logic                         r_key_loaded;
  logic                         r_overrun;
  logic                         r_frame_key;   // current frame carries a key

  logic w_rise;
  logic w_cap_key;
  logic w_cap_data;
  logic w_clr_count;
  logic w_set_overrun;
  logic w_set_key_loaded;
  logic w_last_data;

  fosfor_edge_detect #(.RESET_VAL(1'b1)) u_strobe_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_sig   (i_strobe),
    .o_rise  (w_rise)
  );

  // The count runs across the whole frame, so the last data nibble sits at a
  // different count for key+data frames than for data-only frames.
  assign w_last_data = r_frame_key ? (r_count == COUNT_W'(FRAME_NIBBLES - 1))
                                   : (r_count == COUNT_W'(DATA_NIBBLES - 1));

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_next     = r_state;
    w_cap_key        = 1'b0;
    w_cap_data       = 1'b0;
    w_clr_count      = 1'b0;
    w_set_overrun    = 1'b0;
    w_set_key_loaded = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          if (i_mode) begin
            w_cap_key    = 1'b1;
            w_state_next = LOAD_KEY;
          end else if (r_key_loaded) begin
            w_cap_data   = 1'b1;
            w_state_next = LOAD_DATA;
          end
        end
      end
      LOAD_KEY: begin
        if (w_rise) begin
          w_cap_key = 1'b1;
          if (r_count == COUNT_W'(KEY_NIBBLES - 1)) begin
            w_set_key_loaded = 1'b1;
            w_state_next     = LOAD_DATA;
          end
        end
      end
      LOAD_DATA: begin
        if (w_rise) begin
          w_cap_data = 1'b1;
          if (w_last_data) w_state_next = OFFER;
        end
      end
      OFFER: begin
        // Key and data are frozen here; any new strobe edge is lost.
        w_set_overrun = w_rise;
        if (i_ready) begin
          w_clr_count  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_key        <= '0;
      r_data       <= '0;
      r_count      <= '0;
      r_key_loaded <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_key  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_cap_key)  r_key  <= {r_key[PRESENT_KEY_W-NIBBLE_W-1:0], i_nibble};
      if (w_cap_data) r_data <= {r_data[PRESENT_BLOCK_W-NIBBLE_W-1:0], i_nibble};
      if (w_clr_count)                  r_count <= '0;
      else if (w_cap_key || w_cap_data) r_count <= r_count + COUNT_W'(1);
      if (w_set_key_loaded) r_key_loaded <= 1'b1;
      if (w_set_overrun)    r_overrun    <= 1'b1;
      // Frame type is latched from the first accepted strobe only.
      if (r_state == IDLE && (w_cap_key || w_cap_data)) r_frame_key <= w_cap_key;
    end
  end

  assign o_key        = r_key;
  assign o_data       = r_data;
  assign o_valid      = (r_state == OFFER);
  assign o_busy       = (r_state != IDLE);
  assign o_key_loaded = r_key_loaded;
  assign o_overrun    = r_overrun;
  assign o_count      = r_count;

endmodule

// File: tb/tb_fosfor_present_loader.sv
module tb_fosfor_present_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  nibble = 4'h0;
  logic        strobe = 1'b0;
  logic        mode = 1'b0;
  logic        ready = 1'b0;
  logic [79:0] key;
  logic [63:0] data;
  logic        valid, busy, key_loaded, overrun;
  logic [5:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fosfor_present_loader dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_nibble     (nibble),
    .i_strobe     (strobe),
    .i_mode       (mode),
    .i_ready      (ready),
    .o_key        (key),
    .o_data       (data),
    .o_valid      (valid),
    .o_busy       (busy),
    .o_key_loaded (key_loaded),
    .o_overrun    (overrun),
    .o_count      (count)
  );

  // Behavioural model: a frame is a run of nibbles; the first 20 of a key
  // frame go to the key, the rest to the data; when the frame length is
  // reached the block is on offer until a ready cycle.
  logic [79:0] m_key;
  logic [63:0] m_data;
  int          m_n;
  bit          m_offer, m_frame_key, m_kl, m_ovr, m_prev, m_armed;

  task automatic model_step();
    bit rise, accept;
    if (reset) begin
      m_key = '0; m_data = '0; m_n = 0; m_offer = 0; m_frame_key = 0;
      m_kl = 0; m_ovr = 0; m_prev = 1; m_armed = 1;
    end else begin
      rise   = strobe && !m_prev;
      m_prev = strobe;
      if (m_offer) begin
        if (rise) m_ovr = 1;
        if (ready) begin m_offer = 0; m_n = 0; end
      end else if (rise) begin
        accept = 1;
        if (m_n == 0) begin
          if (mode)      m_frame_key = 1;
          else if (m_kl) m_frame_key = 0;
          else           accept = 0;
        end
        if (accept) begin
          if (m_frame_key && m_n < 20) m_key  = {m_key[75:0], nibble};
          else                         m_data = {m_data[59:0], nibble};
          m_n++;
          if (m_frame_key && m_n == 20) m_kl = 1;
          if (m_n == (m_frame_key ? 36 : 16)) m_offer = 1;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    m_armed = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_armed) begin
        check("model key",        80'(key),        80'(m_key));
        check("model data",       80'(data),       80'(m_data));
        check("model valid",      80'(valid),      80'(m_offer));
        check("model busy",       80'(busy),       80'(m_offer || m_n > 0));
        check("model key_loaded", 80'(key_loaded), 80'(m_kl));
        check("model overrun",    80'(overrun),    80'(m_ovr));
        check("model count",      80'(count),      80'(m_n));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  // Returns on the negedge after the capturing posedge.
  task automatic send_nibble(input logic [3:0] nib, input logic md);
    @(negedge clk); strobe = 1'b1; nibble = nib; mode = md;
    @(negedge clk); strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("reset key",     80'(key), 80'h0);
    check("reset data",    80'(data), 80'h0);
    check("reset valid",   80'(valid), 80'h0);
    check("reset busy",    80'(busy), 80'h0);
    check("reset kl",      80'(key_loaded), 80'h0);
    check("reset overrun", 80'(overrun), 80'h0);
    check("reset count",   80'(count), 80'h0);

    // 1: all-zero key+data frame with ready held high
    ready = 1'b1;
    for (int i = 0; i < 36; i++) send_nibble(4'h0, 1'b1);
    check("t1 valid after last", 80'(valid), 80'h1);
    check("t1 key", 80'(key), 80'h0);
    check("t1 data", 80'(data), 80'h0);
    check("t1 count 36", 80'(count), 80'd36);
    idle(1);
    check("t1 valid one cycle", 80'(valid), 80'h0);
    check("t1 count cleared", 80'(count), 80'h0);
    ready = 1'b0;

    // 2: key all F, data 0..F, then data-only F..0
    for (int i = 0; i < 20; i++) send_nibble(4'hF, 1'b1);
    check("t2 kl after key", 80'(key_loaded), 80'h1);
    for (int i = 0; i < 16; i++) send_nibble(4'(i), 1'b0);
    check("t2 key", 80'(key), 80'hFFFF_FFFF_FFFF_FFFF_FFFF);
    check("t2 data", 80'(data), 80'h0123456789ABCDEF);
    check("t2 valid", 80'(valid), 80'h1);
    ready = 1'b1; idle(1); ready = 1'b0;
    check("t2 handshake", 80'(valid), 80'h0);
    for (int i = 15; i >= 0; i--) send_nibble(4'(i), 1'b0);
    check("t2 key kept", 80'(key), 80'hFFFF_FFFF_FFFF_FFFF_FFFF);
    check("t2 data only", 80'(data), 80'hFEDCBA9876543210);
    check("t2 data only count", 80'(count), 80'd16);
    ready = 1'b1; idle(1); ready = 1'b0;

    // 3: data-only frame without a key is ignored
    do_reset();
    for (int i = 0; i < 5; i++) send_nibble(4'hA, 1'b0);
    check("t3 count", 80'(count), 80'h0);
    check("t3 busy", 80'(busy), 80'h0);
    check("t3 valid", 80'(valid), 80'h0);
    check("t3 data", 80'(data), 80'h0);

    // 4: held strobe is one transfer; strobe high across reset is no edge
    @(negedge clk); strobe = 1'b1; nibble = 4'h3; mode = 1'b1;
    idle(10);
    check("t4 held strobe", 80'(count), 80'd1);
    check("t4 held key", 80'(key), 80'h3);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    idle(3);
    check("t4 strobe across reset", 80'(count), 80'h0);
    strobe = 1'b0; idle(1);
    strobe = 1'b1; idle(1);
    check("t4 re-rise", 80'(count), 80'd1);
    strobe = 1'b0;

    // 5: finish that frame, hold in OFFER with ready low, strobe twice
    for (int i = 0; i < 19; i++) send_nibble(4'h5, 1'b0);
    for (int i = 0; i < 16; i++) send_nibble(4'(i), 1'b0);
    check("t5 key", 80'(key), 80'h3555_5555_5555_5555_5555);
    @(negedge clk); strobe = 1'b1;
    @(negedge clk); strobe = 1'b0;
    @(negedge clk); strobe = 1'b1;
    @(negedge clk); strobe = 1'b0;
    @(negedge clk);
    check("t5 valid held", 80'(valid), 80'h1);
    check("t5 data frozen", 80'(data), 80'h0123456789ABCDEF);
    check("t5 overrun", 80'(overrun), 80'h1);
    ready = 1'b1; idle(1); ready = 1'b0;
    check("t5 valid dropped", 80'(valid), 80'h0);
    check("t5 busy dropped", 80'(busy), 80'h0);
    check("t5 overrun sticky", 80'(overrun), 80'h1);

    // 6: reset mid key load
    do_reset();
    for (int i = 0; i < 10; i++) send_nibble(4'(i + 1), 1'b1);
    check("t6 mid-frame count", 80'(count), 80'd10);
    do_reset();
    check("t6 key", 80'(key), 80'h0);
    check("t6 kl", 80'(key_loaded), 80'h0);
    check("t6 count", 80'(count), 80'h0);
    check("t6 busy", 80'(busy), 80'h0);
    send_nibble(4'h7, 1'b0);
    check("t6 data-only ignored", 80'(count), 80'h0);
    check("t6 data", 80'(data), 80'h0);

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      reset  = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 2) == 0) strobe = ~strobe;
      nibble = 4'($urandom);
      mode   = ($urandom_range(0, 3) != 0);
      ready  = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    reset = 1'b0; strobe = 1'b0; ready = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
